// File: rtl/zircon_ps2_pkg.sv
// zircon_ps2_pkg: shared types and constants for the PS/2
// host-to-device command path.
package zircon_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SHIFT,
    ST_ACK,
    ST_RESP
  } state_e;

  typedef enum logic {
    PH_CMD,
    PH_ARG
  } phase_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NACK    = 2'd2;
  localparam logic [1:0] ERR_RESP    = 2'd3;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_SET_LED   = 8'hED;
  localparam logic [7:0] PS2_RESET     = 8'hFF;
  localparam logic [7:0] PS2_TYPEMATIC = 8'hF3;

  // stop, odd parity, data (LSB first)
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/zircon_ps2_tx_frame.sv
// zircon_ps2_tx_frame: frame build, edge-driven bit shifter,
// data pin drive and device ACK sampling.
module zircon_ps2_tx_frame
  import zircon_ps2_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       ack_en,
  input  logic       fall,
  input  logic       data_s,
  output logic       data_oe,
  output logic       bits_done,
  output logic       frame_done,
  output logic       ack_ok
);

  logic [9:0] frame_q, frame_d;
  logic [3:0] cnt_q, cnt_d;
  logic       oe_q, oe_d;

  assign bits_done  = shift_en & fall & (cnt_q == 4'd9);
  assign frame_done = ack_en & fall;
  assign ack_ok     = ~data_s;
  assign data_oe    = oe_q;

  // load drives the start bit; each falling edge puts out the next bit
  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    if (clear) begin
      oe_d  = 1'b0;
      cnt_d = '0;
    end else if (load) begin
      frame_d = ps2_frame(byte_in);
      cnt_d   = '0;
      oe_d    = 1'b1;
    end else if (shift_en && fall) begin
      oe_d  = ~frame_q[cnt_q];
      cnt_d = cnt_q + 4'd1;
    end
  end

  // frame registers; data pin released on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
    end
  end

endmodule

// File: rtl/zircon_avalon_ps2_cmd_ctrl.sv
// zircon_avalon_ps2_cmd_ctrl: PS/2 command sequencer with retry/timeout.
// ZIRCON_PS2_RESP_CHECK_EN adds the wait for the 0xFA/0xFE response.
module zircon_avalon_ps2_cmd_ctrl
  import zircon_ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5760,
  parameter int unsigned TIMEOUT_CYCLES = 960000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_block,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] LOAD_AT =
    IW'((INHIBIT_CYCLES >= 16) ? INHIBIT_CYCLES - 16 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic            has_arg_q, has_arg_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            clk_oe_q, clk_oe_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  logic       ev_ok, ev_retry;
  logic [1:0] fail_code, retry_code;
  logic       load, clear, shift_en, ack_en;
  logic [7:0] tx_byte;
  logic       frame_oe, bits_done, frame_done, ack_ok;

  assign fall      = clk_prev_q & ~clk_s2_q;
  assign shift_en  = (state_q == ST_SHIFT);
  assign ack_en    = (state_q == ST_ACK);
  assign clk_oe_d  = (state_d == ST_INHIBIT);
  assign clear     = (state_d == ST_IDLE);
  assign load      = (state_d == ST_INHIBIT) && (inh_d == LOAD_AT);
  assign tx_byte   = (phase_d == PH_ARG) ? arg_d : cmd_d;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = ~cmd_ready;
  assign rx_block    = (state_q != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = frame_oe;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

`ifndef ZIRCON_PS2_RESP_CHECK_EN
  logic unused_rx;
  assign unused_rx = ^{rx_valid, rx_byte};
`endif

  zircon_ps2_tx_frame u_frame (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .byte_in    (tx_byte),
    .clear      (clear),
    .shift_en   (shift_en),
    .ack_en     (ack_en),
    .fall       (fall),
    .data_s     (dat_s2_q),
    .data_oe    (frame_oe),
    .bits_done  (bits_done),
    .frame_done (frame_done),
    .ack_ok     (ack_ok)
  );

  // pin synchronizers plus the previous clock sample for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // sequencer: next state, counters, retry and completion decode
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    inh_d      = inh_q;
    tmo_d      = '0;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    ev_ok      = 1'b0;
    ev_retry   = 1'b0;
    fail_code  = ERR_NONE;
    retry_code = ERR_NACK;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d      = cmd_byte;
          arg_d      = cmd_arg;
          has_arg_d  = cmd_has_arg;
          phase_d    = PH_CMD;
          retry_d    = '0;
          err_code_d = ERR_NONE;
          inh_d      = '0;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) state_d = ST_SHIFT;
        else inh_d = inh_q + IW'(1);
      end
      default: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          fail_code = ERR_TIMEOUT;
        end else if (state_q == ST_SHIFT) begin
          if (bits_done) state_d = ST_ACK;
        end else if (state_q == ST_ACK) begin
          if (frame_done) begin
            if (!ack_ok) ev_retry = 1'b1;
`ifdef ZIRCON_PS2_RESP_CHECK_EN
            else state_d = ST_RESP;
`else
            else ev_ok = 1'b1;
`endif
          end
        end
`ifdef ZIRCON_PS2_RESP_CHECK_EN
        else if (rx_valid) begin
          retry_code = ERR_RESP;
          if (rx_byte == PS2_ACK) ev_ok = 1'b1;
          else if (rx_byte == PS2_RESEND) ev_retry = 1'b1;
          else fail_code = ERR_RESP;
        end
`endif
      end
    endcase
    if (ev_ok) begin
      if (phase_q == PH_CMD && has_arg_q) begin
        phase_d = PH_ARG;
        retry_d = '0;
        inh_d   = '0;
        state_d = ST_INHIBIT;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
    if (ev_retry) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RW'(1);
        inh_d   = '0;
        state_d = ST_INHIBIT;
      end else begin
        fail_code = retry_code;
      end
    end
    if (fail_code != ERR_NONE) begin
      error_d    = 1'b1;
      err_code_d = fail_code;
      state_d    = ST_IDLE;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_CMD;
      inh_q      <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
    end
  end

endmodule
